// File: rtl/muu_dedup_hash_dispatch.sv
// ---------------------------------------------------------------------------
// muu_dedup_hash_dispatch
//
// Purpose:
//   Dispatches whole messages from the dedup input stream to a bank of
//   NUM_ENGINES streaming hash engines. Each message goes to the next engine,
//   in round-robin order, that still has room in its result FIFO. Digests are
//   truncated to a HASH_BITS slice and returned strictly in the order the
//   messages arrived. An engine-ID order FIFO records that order.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   input_*             message beat stream in (valid/ready, last marks end)
//   eng_tdata/tlast/    beat stream out to each engine; every tdata slice
//   eng_tvalid/tready     carries input_data, and only the selected engine
//                         sees tvalid
//   eng_digest(_valid)  per-engine digest and single-cycle strobe
//   hash_data/valid/    ordered truncated hash out (valid/ready)
//   hash_ready
//   stat_msg_in         messages dispatched (wraps)
//   stat_msg_out        hashes delivered (wraps)
//   stat_stall          IDLE cycles with input_valid=1 and no dispatch (wraps)
//   err_overflow        sticky: a digest was dropped into a full result FIFO
// ---------------------------------------------------------------------------
module muu_dedup_hash_dispatch #(
   parameter int NUM_ENGINES      = 16,
   parameter int ENG_BITS         = 4,
   parameter int DATA_WIDTH       = 512,
   parameter int DIGEST_WIDTH     = 256,
   parameter int HASH_BITS        = 64,
   parameter int HASH_OFFSET      = 0,
   parameter int OUT_DEPTH_BITS   = 4,
   parameter int ORDER_DEPTH_BITS = 6
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_WIDTH-1:0]                input_data,
   input  logic                                 input_valid,
   input  logic                                 input_last,
   output logic                                 input_ready,
   output logic [NUM_ENGINES*DATA_WIDTH-1:0]    eng_tdata,
   output logic [NUM_ENGINES-1:0]               eng_tlast,
   output logic [NUM_ENGINES-1:0]               eng_tvalid,
   input  logic [NUM_ENGINES-1:0]               eng_tready,
   input  logic [NUM_ENGINES*DIGEST_WIDTH-1:0]  eng_digest,
   input  logic [NUM_ENGINES-1:0]               eng_digest_valid,
   output logic [HASH_BITS-1:0]                 hash_data,
   output logic                                 hash_valid,
   input  logic                                 hash_ready,
   output logic [31:0]                          stat_msg_in,
   output logic [31:0]                          stat_msg_out,
   output logic [31:0]                          stat_stall,
   output logic                                 err_overflow
);

   localparam int OUT_DEPTH   = 1 << OUT_DEPTH_BITS;
   localparam int ORDER_DEPTH = 1 << ORDER_DEPTH_BITS;

   typedef logic [OUT_DEPTH_BITS:0]   resPtr_t;
   typedef logic [ORDER_DEPTH_BITS:0] ordPtr_t;
   typedef logic [ENG_BITS-1:0]       engId_t;

   localparam resPtr_t CREDIT_MAX = resPtr_t'(OUT_DEPTH);
   localparam ordPtr_t ORDER_MAX  = ordPtr_t'(ORDER_DEPTH);
   localparam engId_t  LAST_ENG   = engId_t'(NUM_ENGINES - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   engId_t                r_sel;
   engId_t                r_rr;
   resPtr_t               r_outstanding [NUM_ENGINES];

   engId_t                r_orderMem [ORDER_DEPTH];
   ordPtr_t               r_orderWr;
   ordPtr_t               r_orderRd;

   logic [HASH_BITS-1:0]  r_resMem [NUM_ENGINES][OUT_DEPTH];
   resPtr_t               r_resWr [NUM_ENGINES];
   resPtr_t               r_resRd [NUM_ENGINES];

   logic [31:0]           r_statMsgIn;
   logic [31:0]           r_statMsgOut;
   logic [31:0]           r_statStall;
   logic                  r_errOverflow;

   logic                  w_found;
   engId_t                w_pick;
   engId_t                w_rrNext;
   logic                  w_dispatch;
   logic                  w_orderEmpty;
   logic                  w_orderFull;
   engId_t                w_headId;
   logic                  w_pop;
   logic                  w_beatLast;
   logic [NUM_ENGINES-1:0] w_resEmpty;
   logic [NUM_ENGINES-1:0] w_resFull;
   logic [NUM_ENGINES-1:0] w_resPush;
   logic [NUM_ENGINES-1:0] w_resPop;
   logic [NUM_ENGINES-1:0] w_creditInc;
   logic [NUM_ENGINES-1:0] w_creditDec;
   logic [HASH_BITS-1:0]  w_resHead [NUM_ENGINES];

   // Every engine sees the same beat; only tvalid decides who consumes it.
   assign eng_tdata = {NUM_ENGINES{input_data}};

   assign w_orderEmpty = (r_orderWr == r_orderRd);
   assign w_orderFull  = ((r_orderWr - r_orderRd) == ORDER_MAX);
   assign w_headId     = r_orderMem[r_orderRd[ORDER_DEPTH_BITS-1:0]];

   // The oldest message's hash is only presentable once its own engine has
   // delivered; a faster engine further back in line has to wait.
   assign hash_valid = !w_orderEmpty && !w_resEmpty[w_headId];
   assign hash_data  = w_resHead[w_headId];
   assign w_pop      = hash_valid && hash_ready;

   assign w_dispatch = (r_state == IDLE) && input_valid && !w_orderFull && w_found;
   assign w_rrNext   = (w_pick == LAST_ENG) ? '0 : w_pick + engId_t'(1);
   assign w_beatLast = input_valid && eng_tready[r_sel] && input_last;

   assign stat_msg_in  = r_statMsgIn;
   assign stat_msg_out = r_statMsgOut;
   assign stat_stall   = r_statStall;
   assign err_overflow = r_errOverflow;

   // Round-robin search starting at rr for the first engine whose result
   // FIFO can still take one more digest (outstanding below capacity).
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 0; k < NUM_ENGINES; k++) begin
         if (!w_found && (r_outstanding[(int'(r_rr) + k) % NUM_ENGINES] < CREDIT_MAX)) begin
            w_found = 1'b1;
            w_pick  = engId_t'((int'(r_rr) + k) % NUM_ENGINES);
         end
      end
   end

   // Per-engine result FIFO status, head data and the push/pop/credit strobes.
   // A digest landing on a full FIFO is dropped even if a pop happens in the
   // same cycle, which keeps the overflow condition simple to reason about.
   always_comb begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
         w_resEmpty[i]  = (r_resWr[i] == r_resRd[i]);
         w_resFull[i]   = ((r_resWr[i] - r_resRd[i]) == CREDIT_MAX);
         w_resHead[i]   = r_resMem[i][r_resRd[i][OUT_DEPTH_BITS-1:0]];
         w_resPush[i]   = eng_digest_valid[i] && !w_resFull[i];
         w_resPop[i]    = w_pop && (w_headId == engId_t'(i));
         w_creditInc[i] = w_dispatch && (w_pick == engId_t'(i));
         w_creditDec[i] = w_resPop[i];
      end
   end

   // Next-state and streaming outputs. In STREAM the selected engine is a
   // pure combinational pass-through of valid/last/ready.
   always_comb begin
      w_nextState = r_state;
      input_ready = 1'b0;
      eng_tvalid  = '0;
      eng_tlast   = '0;
      case (r_state)
         IDLE: begin
            if (w_dispatch) begin
               w_nextState = STREAM;
            end
         end
         STREAM: begin
            input_ready       = eng_tready[r_sel];
            eng_tvalid[r_sel] = input_valid;
            eng_tlast[r_sel]  = input_last;
            if (w_beatLast) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // FSM state, selected engine and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_rr    <= '0;
      end else begin
         r_state <= w_nextState;
         if (w_dispatch) begin
            r_sel <= w_pick;
            r_rr  <= w_rrNext;
         end
      end
   end

   // Credits: one per message in flight or waiting at an engine's result
   // FIFO. Dispatch and pop on the same engine in one cycle cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            r_outstanding[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (w_creditInc[i] && !w_creditDec[i]) begin
               r_outstanding[i] <= r_outstanding[i] + resPtr_t'(1);
            end else if (!w_creditInc[i] && w_creditDec[i]) begin
               r_outstanding[i] <= r_outstanding[i] - resPtr_t'(1);
            end
         end
      end
   end

   // Order FIFO and result FIFO pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_orderWr <= '0;
         r_orderRd <= '0;
         for (int i = 0; i < NUM_ENGINES; i++) begin
            r_resWr[i] <= '0;
            r_resRd[i] <= '0;
         end
      end else begin
         if (w_dispatch) begin
            r_orderWr <= r_orderWr + ordPtr_t'(1);
         end
         if (w_pop) begin
            r_orderRd <= r_orderRd + ordPtr_t'(1);
         end
         for (int i = 0; i < NUM_ENGINES; i++) begin
            if (w_resPush[i]) begin
               r_resWr[i] <= r_resWr[i] + resPtr_t'(1);
            end
            if (w_resPop[i]) begin
               r_resRd[i] <= r_resRd[i] + resPtr_t'(1);
            end
         end
      end
   end

   // FIFO storage has no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_dispatch) begin
         r_orderMem[r_orderWr[ORDER_DEPTH_BITS-1:0]] <= w_pick;
      end
      for (int i = 0; i < NUM_ENGINES; i++) begin
         if (w_resPush[i]) begin
            r_resMem[i][r_resWr[i][OUT_DEPTH_BITS-1:0]] <=
               eng_digest[i*DIGEST_WIDTH + HASH_OFFSET +: HASH_BITS];
         end
      end
   end

   // Statistics counters (free-running, wrap at 2^32) and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_statMsgIn   <= '0;
         r_statMsgOut  <= '0;
         r_statStall   <= '0;
         r_errOverflow <= 1'b0;
      end else begin
         if (w_dispatch) begin
            r_statMsgIn <= r_statMsgIn + 32'd1;
         end
         if (w_pop) begin
            r_statMsgOut <= r_statMsgOut + 32'd1;
         end
         if ((r_state == IDLE) && input_valid && !w_dispatch) begin
            r_statStall <= r_statStall + 32'd1;
         end
         if (|(eng_digest_valid & w_resFull)) begin
            r_errOverflow <= 1'b1;
         end
      end
   end

endmodule
